// File: rtl/systolic_array_4x4.sv
// rtl/systolic_array_4x4.sv - output-stationary 4x4 unsigned MAC mesh with run/done control
// Operands enter pre-skewed from the north/west edges and ripple one PE per cycle.
module systolic_array_4x4 #(
   parameter int DATA_W = 16,
   parameter int N      = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [3:0]                 matrix_size,
   input  logic [DATA_W-1:0]          inp_north_0,
   input  logic [DATA_W-1:0]          inp_north_1,
   input  logic [DATA_W-1:0]          inp_north_2,
   input  logic [DATA_W-1:0]          inp_north_3,
   input  logic [DATA_W-1:0]          inp_west_0,
   input  logic [DATA_W-1:0]          inp_west_1,
   input  logic [DATA_W-1:0]          inp_west_2,
   input  logic [DATA_W-1:0]          inp_west_3,
   output logic [N*N*DATA_W-1:0]      final_result,
   output logic                       busy,
   output logic                       done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        cnt;
   logic [3:0]        size_q;
   logic              last_step;
   logic              mac_en;

   logic [DATA_W-1:0] north_top [N];
   logic [DATA_W-1:0] west_left [N];
   logic [DATA_W-1:0] north_in  [N][N];
   logic [DATA_W-1:0] west_in   [N][N];
   logic [DATA_W-1:0] north_q   [N][N];
   logic [DATA_W-1:0] west_q    [N][N];
   logic [DATA_W-1:0] acc       [N][N];

   assign north_top[0] = inp_north_0;
   assign north_top[1] = inp_north_1;
   assign north_top[2] = inp_north_2;
   assign north_top[3] = inp_north_3;
   assign west_left[0] = inp_west_0;
   assign west_left[1] = inp_west_1;
   assign west_left[2] = inp_west_2;
   assign west_left[3] = inp_west_3;

   // PE(3,3) sees the last operand pair K+5 cycles after the first edge of the run
   assign last_step = (cnt == ({1'b0, size_q} + 5'd5));
   // a start edge always clears the mesh instead of accumulating, even mid-run
   assign mac_en    = (state == S_RUN) && !start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = (matrix_size == 4'd0) ? S_DONE : S_RUN;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_RUN:   state_nxt = last_step ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         size_q <= '0;
      end else if (start) begin
         cnt    <= '0;
         size_q <= matrix_size;
      end else if (state == S_RUN) begin
         cnt    <= cnt + 5'd1;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            north_in[i][j] = (i == 0) ? north_top[j] : north_q[(i == 0) ? 0 : i-1][j];
            west_in[i][j]  = (j == 0) ? west_left[i] : west_q[i][(j == 0) ? 0 : j-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc[i][j]     <= '0;
               north_q[i][j] <= '0;
               west_q[i][j]  <= '0;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (mac_en) begin
                  acc[i][j]     <= acc[i][j] + north_in[i][j] * west_in[i][j];
                  north_q[i][j] <= north_in[i][j];
                  west_q[i][j]  <= west_in[i][j];
               end else begin
                  north_q[i][j] <= '0;
                  west_q[i][j]  <= '0;
                  if (start) begin
                     acc[i][j] <= '0;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            final_result[(i*N+j)*DATA_W +: DATA_W] = acc[i][j];
         end
      end
   end

endmodule

// File: tb/tb_systolic_array_4x4.sv
// tb/tb_systolic_array_4x4.sv - randomized self-checking bench for systolic_array_4x4
// Expected results come from a plain matrix-product model of the streamed operands.
module tb_systolic_array_4x4;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [3:0]   matrix_size;
   logic [15:0]  nin [4];
   logic [15:0]  win [4];
   logic [255:0] final_result;
   logic         busy;
   logic         done;

   // a[i][k] feeds row i (west), b[k][j] feeds column j (north)
   logic [15:0]  a [4][16];
   logic [15:0]  b [16][4];

   int checks;
   int errors;

   systolic_array_4x4 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .matrix_size  (matrix_size),
      .inp_north_0  (nin[0]),
      .inp_north_1  (nin[1]),
      .inp_north_2  (nin[2]),
      .inp_north_3  (nin[3]),
      .inp_west_0   (win[0]),
      .inp_west_1   (win[1]),
      .inp_west_2   (win[2]),
      .inp_west_3   (win[3]),
      .final_result (final_result),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] model(input int size);
      logic [255:0] r;
      logic [15:0]  s;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = 16'd0;
            for (int k = 0; k < size; k++) s = s + a[i][k] * b[k][j];
            r[(i*4+j)*16 +: 16] = s;
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic garbage_lanes();
      for (int j = 0; j < 4; j++) begin
         nin[j] = 16'($urandom);
         win[j] = 16'($urandom);
      end
   endtask

   // drive the feeder's skewed view of the streams for run step t
   task automatic set_lanes(input int t, input int size);
      for (int j = 0; j < 4; j++) begin
         nin[j] = (t - j >= 0 && t - j < size) ? b[t-j][j] : 16'd0;
         win[j] = (t - j >= 0 && t - j < size) ? a[j][t-j] : 16'd0;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 16; k++) begin
            a[i][k] = 16'($urandom);
            b[k][i] = 16'($urandom);
         end
   endtask

   // stop_at >= 0 returns just before run step stop_at, leaving the DUT in RUN
   task automatic run(input string tag, input int size, input int stop_at);
      logic [255:0] exp;
      int busy_cycles;
      start       = 1'b1;
      matrix_size = 4'(size);
      garbage_lanes();
      tick();
      start       = 1'b0;
      matrix_size = 4'($urandom);
      exp = model(size);
      if (size == 0) begin
         check_val({tag, "_z_flags"}, {254'd0, busy, done}, 256'd1);
         check_val({tag, "_z_res"}, final_result, exp);
         tick();
         check_val({tag, "_z_after"}, {254'd0, busy, done}, 256'd0);
         return;
      end
      busy_cycles = 0;
      for (int t = 0; t <= size + 5; t++) begin
         if (stop_at >= 0 && t == stop_at) return;
         set_lanes(t, size);
         if (busy) busy_cycles++;
         if (done) check_val({tag, "_early_done"}, {255'd0, done}, 256'd0);
         tick();
      end
      garbage_lanes();
      check_val({tag, "_done"}, {254'd0, busy, done}, 256'd1);
      check_val({tag, "_busy_len"}, 256'(busy_cycles), 256'(size + 6));
      check_val({tag, "_res"}, final_result, exp);
      tick();
      check_val({tag, "_post"}, {254'd0, busy, done}, 256'd0);
      check_val({tag, "_hold"}, final_result, exp);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      matrix_size = 4'd0;
      garbage_lanes();
      tick();
      tick();
      check_val("reset_flags", {254'd0, busy, done}, 256'd0);
      check_val("reset_res", final_result, 256'd0);
      rst_n = 1'b1;
      tick();

      // all-3 against all-5, single step
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 16; k++) begin
            a[i][k] = 16'd5;
            b[k][i] = 16'd3;
         end
      run("t1", 1, -1);
      check_val("t1_val", final_result[15:0], 256'd15);

      // identity times B gives B
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++) begin
            a[i][k] = (i == k) ? 16'd1 : 16'd0;
            b[i][k] = 16'(i*4 + k + 1);
         end
      run("t2", 4, -1);
      check_val("t2_b33", final_result[255:240], 256'd16);

      // modulo 2^16 wrap
      for (int i = 0; i < 4; i++) begin
         a[i][0] = 16'h00FF;
         b[0][i] = 16'h0101;
         a[i][1] = 16'h0001;
         b[1][i] = 16'h0001;
      end
      run("t3a", 2, -1);
      check_val("t3a_wrap", final_result[15:0], 256'h0000);
      run("t3b", 1, -1);
      check_val("t3b_full", final_result[15:0], 256'hFFFF);

      // zero-length run after a nonzero result
      run("t4", 0, -1);

      // restart mid-run with a different size and stream
      fill_random();
      run("t5a", 4, 3);
      fill_random();
      run("t5b", 2, -1);

      // asynchronous reset mid-run
      fill_random();
      run("t6", 6, 4);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_flags", {254'd0, busy, done}, 256'd0);
      check_val("t6_rst_res", final_result, 256'd0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         garbage_lanes();
         tick();
         if (done || busy) check_val("t6_idle", {254'd0, busy, done}, 256'd0);
      end
      check_val("t6_idle_res", final_result, 256'd0);

      for (int r = 0; r < 6; r++) begin
         fill_random();
         run("rnd", $urandom_range(1, 15), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
